// File: rtl/game_ctrl.sv
// Turn sequencer for a 3x3 tic-tac-toe board: validates move requests, pulses one box
// select for the current player, then scores the board for a win or draw.
module game_ctrl #(
    parameter logic FIRST_PLAYER = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        move_valid,
    input  logic [3:0]  move_idx,
    input  logic [17:0] board,
    output logic        move_ready,
    output logic [8:0]  box_select,
    output logic        cur_player,
    output logic        illegal,
    output logic        game_over,
    output logic [1:0]  winner,
    output logic [3:0]  turn_count
);

    typedef enum logic [1:0] {
        S_WAIT,
        S_COMMIT,
        S_CHECK,
        S_DONE
    } state_t;

    state_t      r_state;
    logic [8:0]  r_box_select;
    logic        r_cur_player;
    logic        r_illegal;
    logic        r_game_over;
    logic [1:0]  r_winner;
    logic [3:0]  r_turn_count;

    logic [1:0]  w_box [9];
    logic        w_box_free;
    logic        w_legal;
    logic [8:0]  w_onehot;
    logic [1:0]  w_win;

    // Returns the shared code when all three boxes hold the same nonzero code, else 00.
    function automatic logic [1:0] line_win(input logic [1:0] a, input logic [1:0] b,
                                            input logic [1:0] c);
        return ((a != 2'b00) && (a == b) && (b == c)) ? a : 2'b00;
    endfunction

    always_comb begin
        w_box_free = 1'b0;
        for (int i = 0; i < 9; i++) begin
            w_box[i] = board[2*i +: 2];
            if (move_idx == 4'(i))
                w_box_free = (board[2*i +: 2] == 2'b00);
        end
    end

    // An out-of-range index never matches a box above, so w_box_free stays low for it.
    assign w_legal  = (move_idx <= 4'd8) && w_box_free;
    assign w_onehot = 9'b1 << move_idx;

    always_comb begin
        w_win = line_win(w_box[0], w_box[1], w_box[2]);
        if (w_win == 2'b00) w_win = line_win(w_box[3], w_box[4], w_box[5]);
        if (w_win == 2'b00) w_win = line_win(w_box[6], w_box[7], w_box[8]);
        if (w_win == 2'b00) w_win = line_win(w_box[0], w_box[3], w_box[6]);
        if (w_win == 2'b00) w_win = line_win(w_box[1], w_box[4], w_box[7]);
        if (w_win == 2'b00) w_win = line_win(w_box[2], w_box[5], w_box[8]);
        if (w_win == 2'b00) w_win = line_win(w_box[0], w_box[4], w_box[8]);
        if (w_win == 2'b00) w_win = line_win(w_box[2], w_box[4], w_box[6]);
    end

    // NOTE: state registers use non-blocking assignments so every branch sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_WAIT;
            r_box_select <= '0;
            r_cur_player <= FIRST_PLAYER;
            r_illegal    <= 1'b0;
            r_game_over  <= 1'b0;
            r_winner     <= 2'b00;
            r_turn_count <= '0;
        end else begin
            // NOTE: default-low here makes illegal a single-cycle pulse without extra state.
            r_illegal <= 1'b0;
            case (r_state)
                S_WAIT: begin
                    if (move_valid) begin
                        if (w_legal) begin
                            r_box_select <= w_onehot;
                            r_state      <= S_COMMIT;
                        end else begin
                            r_illegal <= 1'b1;
                        end
                    end
                end
                S_COMMIT: begin
                    r_box_select <= '0;
                    if (r_turn_count != 4'd9)
                        r_turn_count <= r_turn_count + 4'd1;
                    r_state <= S_CHECK;
                end
                S_CHECK: begin
                    // The box latched at the end of COMMIT, so board already holds this move.
                    if (w_win != 2'b00) begin
                        r_winner    <= w_win;
                        r_game_over <= 1'b1;
                        r_state     <= S_DONE;
                    end else if (r_turn_count == 4'd9) begin
                        r_winner    <= 2'b11;
                        r_game_over <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_cur_player <= ~r_cur_player;
                        r_state      <= S_WAIT;
                    end
                end
                S_DONE: r_state <= S_DONE;
                default: r_state <= S_WAIT;
            endcase
        end
    end

    assign move_ready = (r_state == S_WAIT);
    assign box_select = r_box_select;
    assign cur_player = r_cur_player;
    assign illegal    = r_illegal;
    assign game_over  = r_game_over;
    assign winner     = r_winner;
    assign turn_count = r_turn_count;

endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl: table of moves with hand-computed responses plus
// hand-written sequences for moves in DONE and reset during COMMIT.
module tb_game_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        move_valid;
    logic [3:0]  move_idx;
    logic [17:0] board;
    logic        move_ready;
    logic [8:0]  box_select;
    logic        cur_player;
    logic        illegal;
    logic        game_over;
    logic [1:0]  winner;
    logic [3:0]  turn_count;

    int n_checks = 0;
    int n_errors = 0;

    game_ctrl #(.FIRST_PLAYER(1'b0)) dut (
        .clk        (clk),
        .reset      (reset),
        .move_valid (move_valid),
        .move_idx   (move_idx),
        .board      (board),
        .move_ready (move_ready),
        .box_select (box_select),
        .cur_player (cur_player),
        .illegal    (illegal),
        .game_over  (game_over),
        .winner     (winner),
        .turn_count (turn_count)
    );

    always #5 clk = ~clk;

    // Nine box instances: cleared by reset, latch the current player's code when selected.
    always @(posedge clk) begin
        if (reset) board <= '0;
        else
            for (int i = 0; i < 9; i++)
                if (box_select[i]) board[2*i +: 2] <= cur_player ? 2'b10 : 2'b01;
    end

    typedef struct {
        logic       rst;     // reset before this move
        logic [3:0] idx;
        logic       legal;
        logic [8:0] sel;     // expected box_select in COMMIT
        logic       cm;      // player committing the move
        logic       after;   // cur_player once back in WAIT/DONE
        logic [3:0] turns;
        logic       over;
        logic [1:0] win;
    } vec_t;

    vec_t vecs[27];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        move_valid = 1'b0;
        move_idx   = 4'd0;
        tick();
        tick();
        check("rst move_ready", 32'(move_ready), 32'd1);
        check("rst box_select", 32'(box_select), 32'd0);
        check("rst cur_player", 32'(cur_player), 32'd0);
        check("rst illegal", 32'(illegal), 32'd0);
        check("rst game_over", 32'(game_over), 32'd0);
        check("rst winner", 32'(winner), 32'd0);
        check("rst turn_count", 32'(turn_count), 32'd0);
        check("rst board", 32'(board), 32'd0);
        reset = 1'b0;
    endtask

    task automatic apply(input vec_t v);
        check("pre move_ready", 32'(move_ready), 32'd1);
        move_valid = 1'b1;
        move_idx   = v.idx;
        tick();
        move_valid = 1'b0;
        if (v.legal) begin
            check("commit box_select", 32'(box_select), 32'(v.sel));
            check("commit illegal", 32'(illegal), 32'd0);
            check("commit cur_player", 32'(cur_player), 32'(v.cm));
            check("commit move_ready", 32'(move_ready), 32'd0);
            tick();
            check("check box_select", 32'(box_select), 32'd0);
            check("check turn_count", 32'(turn_count), 32'(v.turns));
            check("check move_ready", 32'(move_ready), 32'd0);
            check("check box latched", 32'(board[2*v.idx +: 2]), v.cm ? 32'd2 : 32'd1);
            tick();
            check("after move_ready", 32'(move_ready), v.over ? 32'd0 : 32'd1);
            check("after game_over", 32'(game_over), 32'(v.over));
            check("after winner", 32'(winner), 32'(v.win));
            check("after cur_player", 32'(cur_player), 32'(v.after));
        end else begin
            check("illegal pulse", 32'(illegal), 32'd1);
            check("illegal box_select", 32'(box_select), 32'd0);
            check("illegal move_ready", 32'(move_ready), 32'd1);
            tick();
            check("illegal clears", 32'(illegal), 32'd0);
            check("illegal turn_count", 32'(turn_count), 32'(v.turns));
            check("illegal cur_player", 32'(cur_player), 32'(v.after));
            check("illegal box_select2", 32'(box_select), 32'd0);
        end
    endtask

    task automatic run_range(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            if (vecs[i].rst) do_reset();
            apply(vecs[i]);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Game A: centre move, then occupied and out-of-range requests.
        vecs[0]  = '{1'b1, 4'd4,  1'b1, 9'h010, 1'b0, 1'b1, 4'd1, 1'b0, 2'b00};
        vecs[1]  = '{1'b0, 4'd4,  1'b0, 9'h000, 1'b0, 1'b1, 4'd1, 1'b0, 2'b00};
        vecs[2]  = '{1'b0, 4'd9,  1'b0, 9'h000, 1'b0, 1'b1, 4'd1, 1'b0, 2'b00};
        vecs[3]  = '{1'b0, 4'd15, 1'b0, 9'h000, 1'b0, 1'b1, 4'd1, 1'b0, 2'b00};
        // Game B: p0 takes the top row on move 5.
        vecs[4]  = '{1'b1, 4'd0,  1'b1, 9'h001, 1'b0, 1'b1, 4'd1, 1'b0, 2'b00};
        vecs[5]  = '{1'b0, 4'd3,  1'b1, 9'h008, 1'b1, 1'b0, 4'd2, 1'b0, 2'b00};
        vecs[6]  = '{1'b0, 4'd1,  1'b1, 9'h002, 1'b0, 1'b1, 4'd3, 1'b0, 2'b00};
        vecs[7]  = '{1'b0, 4'd4,  1'b1, 9'h010, 1'b1, 1'b0, 4'd4, 1'b0, 2'b00};
        vecs[8]  = '{1'b0, 4'd2,  1'b1, 9'h004, 1'b0, 1'b0, 4'd5, 1'b1, 2'b01};
        // Game C: 0,1,2,4,3,5,7,6,8 fills the board with no line -> draw.
        vecs[9]  = '{1'b1, 4'd0,  1'b1, 9'h001, 1'b0, 1'b1, 4'd1, 1'b0, 2'b00};
        vecs[10] = '{1'b0, 4'd1,  1'b1, 9'h002, 1'b1, 1'b0, 4'd2, 1'b0, 2'b00};
        vecs[11] = '{1'b0, 4'd2,  1'b1, 9'h004, 1'b0, 1'b1, 4'd3, 1'b0, 2'b00};
        vecs[12] = '{1'b0, 4'd4,  1'b1, 9'h010, 1'b1, 1'b0, 4'd4, 1'b0, 2'b00};
        vecs[13] = '{1'b0, 4'd3,  1'b1, 9'h008, 1'b0, 1'b1, 4'd5, 1'b0, 2'b00};
        vecs[14] = '{1'b0, 4'd5,  1'b1, 9'h020, 1'b1, 1'b0, 4'd6, 1'b0, 2'b00};
        vecs[15] = '{1'b0, 4'd7,  1'b1, 9'h080, 1'b0, 1'b1, 4'd7, 1'b0, 2'b00};
        vecs[16] = '{1'b0, 4'd6,  1'b1, 9'h040, 1'b1, 1'b0, 4'd8, 1'b0, 2'b00};
        vecs[17] = '{1'b0, 4'd8,  1'b1, 9'h100, 1'b0, 1'b0, 4'd9, 1'b1, 2'b11};
        // Game D: 0,1,2,4,3,5,7,8,6 -> p0 completes column 0 on the 9th move.
        vecs[18] = '{1'b1, 4'd0,  1'b1, 9'h001, 1'b0, 1'b1, 4'd1, 1'b0, 2'b00};
        vecs[19] = '{1'b0, 4'd1,  1'b1, 9'h002, 1'b1, 1'b0, 4'd2, 1'b0, 2'b00};
        vecs[20] = '{1'b0, 4'd2,  1'b1, 9'h004, 1'b0, 1'b1, 4'd3, 1'b0, 2'b00};
        vecs[21] = '{1'b0, 4'd4,  1'b1, 9'h010, 1'b1, 1'b0, 4'd4, 1'b0, 2'b00};
        vecs[22] = '{1'b0, 4'd3,  1'b1, 9'h008, 1'b0, 1'b1, 4'd5, 1'b0, 2'b00};
        vecs[23] = '{1'b0, 4'd5,  1'b1, 9'h020, 1'b1, 1'b0, 4'd6, 1'b0, 2'b00};
        vecs[24] = '{1'b0, 4'd7,  1'b1, 9'h080, 1'b0, 1'b1, 4'd7, 1'b0, 2'b00};
        vecs[25] = '{1'b0, 4'd8,  1'b1, 9'h100, 1'b1, 1'b0, 4'd8, 1'b0, 2'b00};
        vecs[26] = '{1'b0, 4'd6,  1'b1, 9'h040, 1'b0, 1'b0, 4'd9, 1'b1, 2'b01};

        reset      = 1'b1;
        move_valid = 1'b0;
        move_idx   = 4'd0;

        run_range(0, 9);

        // Game B is in DONE: a request on a free box must be ignored.
        move_valid = 1'b1;
        move_idx   = 4'd5;
        tick();
        check("done box_select", 32'(box_select), 32'd0);
        check("done illegal", 32'(illegal), 32'd0);
        move_idx = 4'd0;
        tick();
        check("done illegal occupied", 32'(illegal), 32'd0);
        move_valid = 1'b0;
        tick();
        check("done turn_count", 32'(turn_count), 32'd5);
        check("done game_over", 32'(game_over), 32'd1);
        check("done winner", 32'(winner), 32'd1);
        check("done move_ready", 32'(move_ready), 32'd0);
        check("done box5 empty", 32'(board[11:10]), 32'd0);

        run_range(9, 27);

        // Reset asserted while a move sits in COMMIT.
        do_reset();
        move_valid = 1'b1;
        move_idx   = 4'd0;
        tick();
        move_valid = 1'b0;
        check("abort commit select", 32'(box_select), 32'h001);
        reset = 1'b1;
        tick();
        check("abort box_select", 32'(box_select), 32'd0);
        check("abort turn_count", 32'(turn_count), 32'd0);
        check("abort move_ready", 32'(move_ready), 32'd1);
        check("abort board", 32'(board), 32'd0);
        check("abort cur_player", 32'(cur_player), 32'd0);
        reset = 1'b0;
        tick();
        check("abort board held", 32'(board), 32'd0);
        check("abort turn held", 32'(turn_count), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
